hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core.
- Drives hold/flush enables for PC, IF/ID, ID/EX and EX/MEM, and operand forwarding selects for EX.
- Handles load-use stalls, taken-branch/jump redirects, multi-cycle EX operations (with timeout) and a post-reset pipeline flush.
- Sits beside id_ex; its enables gate that register and its neighbours.

Parameters:
- INIT_FLUSH_CYCLES, 2, cycles of forced bubbles after reset release (1..15).
- MC_TIMEOUT, 64, max cycles in multi-cycle wait before abort (2..255).
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- id_rs1  in  5  rs1 address of the instruction in ID.
- id_rs2  in  5  rs2 address of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_rs1  in  5  rs1 address held in ID/EX.
- ex_rs2  in  5  rs2 address held in ID/EX.
- ex_rd  in  5  rd held in ID/EX.
- ex_mem_read  in  1  ID/EX instruction is a load.
- mem_rd  in  5  rd held in EX/MEM.
- mem_reg_write  in  1  EX/MEM writes the register file.
- wb_rd  in  5  rd held in MEM/WB.
- wb_reg_write  in  1  MEM/WB writes the register file.
- ex_redirect  in  1  taken branch/jump resolved in EX this cycle.
- ex_mc_start  in  1  multi-cycle op occupies EX this cycle (first cycle).
- ex_mc_done  in  1  multi-cycle unit result valid.
- pc_en  out  1  PC update enable.
- if_id_en  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID loads NOP.
- id_ex_en  out  1  ID/EX load enable.
- id_ex_flush  out  1  ID/EX loads bubble (wb/m controls zero).
- ex_mem_bubble  out  1  EX/MEM loads bubble.
- fwd_a  out  2  EX operand A source: 00 ID/EX, 01 MEM/WB, 10 EX/MEM.
- fwd_b  out  2  EX operand B source, same encoding.
- mc_timeout  out  1  one-cycle pulse on multi-cycle abort.
- stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0.

Behaviour:
- FSM states: INIT, RUN, MC_WAIT. rst_n=0 at a clock edge -> state INIT, init counter=0, mc counter=0, stall_cnt=0, mc_timeout=0. This applies mid-operation too.
- Enables/flushes/fwd are combinational from state and inputs. fwd_* are additionally forced 00 whenever state != RUN.
- INIT:
  - pc_en=0, if_id_en=1, if_id_flush=1, id_ex_en=1, id_ex_flush=1, ex_mem_bubble=1.
  - Stays INIT_FLUSH_CYCLES cycles after rst_n high, then -> RUN.
  - While rst_n=0, outputs hold INIT values.
- Forwarding (RUN only), per operand:
  - 10 if mem_reg_write && mem_rd!=0 && mem_rd==ex_rsX.
  - Else 01 if wb_reg_write && wb_rd!=0 && wb_rd==ex_rsX.
  - Else 00. EX/MEM has priority over MEM/WB.
- Load-use (RUN): ex_mem_read && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
  - pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1. Exactly one bubble per hazard; no state change.
- Redirect (RUN): ex_redirect=1 -> pc_en=1, if_id_flush=1, id_ex_flush=1 (both enables 1).
  - Redirect overrides a simultaneous load-use stall.
- Multi-cycle (RUN):
  - ex_mc_start=1 && ex_mc_done=0 -> next state MC_WAIT, mc counter=1.
  - In the start cycle itself: pc_en=0, if_id_en=0, id_ex_en=0.
  - ex_mc_start and ex_mc_done in the same cycle -> no stall, stay RUN.
  - ex_mc_start with ex_redirect -> redirect takes effect; the MC op is also honoured (enter MC_WAIT).
- MC_WAIT:
  - pc_en=0, if_id_en=0, id_ex_en=0, ex_mem_bubble=1; ex_redirect ignored.
  - ex_mc_done=1 -> that cycle ex_mem_bubble=0, id_ex_en=1, pc_en=1, if_id_en=1; next state RUN.
  - mc counter reaches MC_TIMEOUT without done -> mc_timeout=1 for one cycle, ex_mem_bubble=1, enables released, -> RUN.
- Default RUN with no hazard: all enables 1, flushes/bubble 0.
- stall_cnt: increments on every post-reset cycle with pc_en=0 (INIT included), saturates at all-ones. Registered; visible the cycle after.
- x0 never triggers stall or forwarding.

Test Plan:
- Reset: hold rst_n=0 3 cycles, release -> pc_en=0 and flushes=1 for exactly 2 cycles, then pc_en=1; stall_cnt=2 afterwards.
- Forwarding: ex_rs1=5, mem_rd=5 and wb_rd=5 both writing -> fwd_a=10; with mem_reg_write=0 -> fwd_a=01; ex_rs2=0, mem_rd=0 -> fwd_b=00.
- Load-use: ex_mem_read=1, ex_rd=7, id_rs2=7, id_use_rs2=1 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1. Same with ex_redirect=1 -> pc_en=1, both flushes=1.
- Multi-cycle: ex_mc_start pulse, ex_mc_done 4 cycles later -> pc_en=0 for 4 cycles, release on the done cycle, stall_cnt +4.
- Timeout: MC_TIMEOUT=8, ex_mc_start with no done -> mc_timeout pulses after 8 cycles, state RUN, ex_mem_bubble=1 that cycle.
- Reset mid-MC_WAIT: rst_n=0 in the 3rd wait cycle -> state INIT next cycle, stall_cnt=0, no mc_timeout.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: hold/flush enables for PC, IF/ID, ID/EX, EX/MEM
// and EX operand forwarding selects for the 5-stage core.
module hazard_ctrl #(
    parameter int unsigned INIT_FLUSH_CYCLES = 2,
    parameter int unsigned MC_TIMEOUT        = 64,
    parameter int unsigned CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    input  logic             ex_redirect,
    input  logic             ex_mc_start,
    input  logic             ex_mc_done,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mc_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned REG_W  = 5;
    localparam int unsigned INIT_W = 4;
    localparam int unsigned MC_W   = 8;

    localparam logic [1:0] FWD_IDEX  = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_MC_WAIT = 2'd2
    } state_t;

    state_t            state;
    logic [INIT_W-1:0] init_cnt;
    logic [MC_W-1:0]   mc_cnt;

    logic load_use;
    logic mc_begin;
    logic mc_expire;
    logic init_last;

    // Youngest producer wins; x0 is hardwired zero and never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] rs,
        input logic             m_we,
        input logic [REG_W-1:0] m_rd,
        input logic             w_we,
        input logic [REG_W-1:0] w_rd
    );
        logic [1:0] sel;
        sel = FWD_IDEX;
        if (m_we && (m_rd != '0) && (m_rd == rs)) begin
            sel = FWD_EXMEM;
        end else if (w_we && (w_rd != '0) && (w_rd == rs)) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

    always_comb begin
        load_use  = ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));
        mc_begin  = ex_mc_start && !ex_mc_done;
        mc_expire = (mc_cnt == MC_W'(MC_TIMEOUT - 1));
        init_last = (init_cnt == INIT_W'(INIT_FLUSH_CYCLES - 1));
    end

    // Stage enables, flushes and forwarding selects.
    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_bubble = 1'b0;
        fwd_a         = FWD_IDEX;
        fwd_b         = FWD_IDEX;

        if (!rst_n || (state == ST_INIT)) begin
            pc_en         = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_bubble = 1'b1;
        end else if (state == ST_RUN) begin
            fwd_a         = fwd_sel(ex_rs1, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
            fwd_b         = fwd_sel(ex_rs2, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
            // Result of an aborted multi-cycle op must not reach MEM.
            ex_mem_bubble = mc_timeout || mc_begin;
            if (ex_redirect) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (mc_begin) begin
                pc_en    = 1'b0;
                if_id_en = 1'b0;
                id_ex_en = 1'b0;
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end else if (state == ST_MC_WAIT) begin
            if (!ex_mc_done) begin
                pc_en         = 1'b0;
                if_id_en      = 1'b0;
                id_ex_en      = 1'b0;
                ex_mem_bubble = 1'b1;
            end
        end else begin
            pc_en         = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_bubble = 1'b1;
        end
    end

    // Sequencing state, multi-cycle watchdog and stall statistics.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_INIT;
            init_cnt   <= '0;
            mc_cnt     <= '0;
            mc_timeout <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            mc_timeout <= 1'b0;
            if (!pc_en && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end

            case (state)
                ST_INIT: begin
                    if (init_last) begin
                        state <= ST_RUN;
                    end else begin
                        init_cnt <= init_cnt + INIT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (mc_begin) begin
                        state  <= ST_MC_WAIT;
                        mc_cnt <= MC_W'(1);
                    end
                end
                ST_MC_WAIT: begin
                    if (ex_mc_done) begin
                        state  <= ST_RUN;
                        mc_cnt <= '0;
                    end else if (mc_expire) begin
                        state      <= ST_RUN;
                        mc_cnt     <= '0;
                        mc_timeout <= 1'b1;
                    end else begin
                        mc_cnt <= mc_cnt + MC_W'(1);
                    end
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: reset flush, forwarding, load-use, redirect,
// multi-cycle wait, timeout abort and reset during a multi-cycle wait.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic        id_use_rs1, id_use_rs2, ex_mem_read, mem_reg_write, wb_reg_write;
    logic        ex_redirect, ex_mc_start, ex_mc_done;
    logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_bubble;
    logic [1:0]  fwd_a, fwd_b;
    logic        mc_timeout;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    hazard_ctrl #(
        .INIT_FLUSH_CYCLES(2),
        .MC_TIMEOUT(8),
        .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .ex_redirect(ex_redirect), .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_bubble(ex_mem_bubble),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mc_timeout(mc_timeout), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_mem_read = 1'b0;
        mem_rd = '0; mem_reg_write = 1'b0; wb_rd = '0; wb_reg_write = 1'b0;
        ex_redirect = 1'b0; ex_mc_start = 1'b0; ex_mc_done = 1'b0;
    endtask

    task automatic set_load_use();
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();

        // Reset held three cycles
        repeat (3) cyc();
        check("rst_pc_en", 32'(pc_en), 0);
        check("rst_id_ex_flush", 32'(id_ex_flush), 1);
        check("rst_bubble", 32'(ex_mem_bubble), 1);
        check("rst_stall_cnt", 32'(stall_cnt), 0);
        check("rst_mc_timeout", 32'(mc_timeout), 0);

        // Two forced-bubble cycles after release
        rst_n = 1'b1;
        #1;
        check("init0_pc_en", 32'(pc_en), 0);
        check("init0_if_id_flush", 32'(if_id_flush), 1);
        cyc();
        check("init1_pc_en", 32'(pc_en), 0);
        check("init1_stall_cnt", 32'(stall_cnt), 1);
        cyc();
        check("run_pc_en", 32'(pc_en), 1);
        check("run_if_id_flush", 32'(if_id_flush), 0);
        check("run_bubble", 32'(ex_mem_bubble), 0);
        check("run_stall_cnt", 32'(stall_cnt), 2);

        // Forwarding priority and x0
        ex_rs1 = 5'd5; mem_rd = 5'd5; mem_reg_write = 1'b1; wb_rd = 5'd5; wb_reg_write = 1'b1;
        #1;
        check("fwd_a_exmem", 32'(fwd_a), 2);
        mem_reg_write = 1'b0;
        #1;
        check("fwd_a_memwb", 32'(fwd_a), 1);
        ex_rs2 = 5'd0; mem_rd = 5'd0; mem_reg_write = 1'b1; wb_rd = 5'd0;
        #1;
        check("fwd_b_x0", 32'(fwd_b), 0);
        ex_rs1 = 5'd6; ex_rs2 = 5'd3; wb_rd = 5'd3;
        #1;
        check("fwd_a_none", 32'(fwd_a), 0);
        check("fwd_b_memwb", 32'(fwd_b), 1);

        // Load-use stall
        cyc();
        idle();
        set_load_use();
        #1;
        check("lu_pc_en", 32'(pc_en), 0);
        check("lu_if_id_en", 32'(if_id_en), 0);
        check("lu_id_ex_en", 32'(id_ex_en), 1);
        check("lu_id_ex_flush", 32'(id_ex_flush), 1);
        check("lu_if_id_flush", 32'(if_id_flush), 0);
        cyc();
        idle();
        #1;
        check("lu_release_pc_en", 32'(pc_en), 1);
        check("lu_stall_cnt", 32'(stall_cnt), 3);
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_use_rs2 = 1'b1;
        #1;
        check("lu_x0_pc_en", 32'(pc_en), 1);
        ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b0;
        #1;
        check("lu_nouse_pc_en", 32'(pc_en), 1);

        // Redirect overrides load-use
        set_load_use();
        ex_redirect = 1'b1;
        #1;
        check("redir_pc_en", 32'(pc_en), 1);
        check("redir_if_id_en", 32'(if_id_en), 1);
        check("redir_if_id_flush", 32'(if_id_flush), 1);
        check("redir_id_ex_flush", 32'(id_ex_flush), 1);
        cyc();
        idle();

        // Multi-cycle op, done four cycles after start
        ex_mc_start = 1'b1;
        #1;
        check("mc_start_stall_cnt", 32'(stall_cnt), 3);
        check("mc_start_pc_en", 32'(pc_en), 0);
        check("mc_start_if_id_en", 32'(if_id_en), 0);
        check("mc_start_id_ex_en", 32'(id_ex_en), 0);
        cyc();
        idle();
        ex_redirect = 1'b1; ex_rs1 = 5'd5; mem_rd = 5'd5; mem_reg_write = 1'b1;
        #1;
        check("mcw_pc_en", 32'(pc_en), 0);
        check("mcw_bubble", 32'(ex_mem_bubble), 1);
        check("mcw_redir_ignored", 32'(if_id_flush), 0);
        check("mcw_fwd_forced", 32'(fwd_a), 0);
        cyc();
        idle();
        #1;
        check("mcw2_pc_en", 32'(pc_en), 0);
        cyc();
        #1;
        check("mcw3_id_ex_en", 32'(id_ex_en), 0);
        cyc();
        ex_mc_done = 1'b1;
        #1;
        check("mc_done_pc_en", 32'(pc_en), 1);
        check("mc_done_id_ex_en", 32'(id_ex_en), 1);
        check("mc_done_bubble", 32'(ex_mem_bubble), 0);
        check("mc_done_stall_cnt", 32'(stall_cnt), 7);
        cyc();
        idle();
        ex_rs1 = 5'd9; mem_rd = 5'd9; mem_reg_write = 1'b1;
        #1;
        check("mc_after_pc_en", 32'(pc_en), 1);
        check("mc_after_fwd_a", 32'(fwd_a), 2);

        // Start and done together: no stall
        idle();
        ex_mc_start = 1'b1; ex_mc_done = 1'b1;
        #1;
        check("mc_same_pc_en", 32'(pc_en), 1);
        cyc();
        idle();
        #1;
        check("mc_same_run_pc_en", 32'(pc_en), 1);
        check("mc_same_stall_cnt", 32'(stall_cnt), 7);

        // Timeout: start with no done, abort after 8 cycles
        ex_mc_start = 1'b1;
        cyc();
        idle();
        repeat (6) cyc();
        #1;
        check("to_c7_pc_en", 32'(pc_en), 0);
        check("to_c7_mc_timeout", 32'(mc_timeout), 0);
        cyc();
        check("to_pulse", 32'(mc_timeout), 1);
        check("to_pc_en", 32'(pc_en), 1);
        check("to_id_ex_en", 32'(id_ex_en), 1);
        check("to_bubble", 32'(ex_mem_bubble), 1);
        check("to_stall_cnt", 32'(stall_cnt), 15);
        cyc();
        check("to_pulse_end", 32'(mc_timeout), 0);
        check("to_bubble_end", 32'(ex_mem_bubble), 0);

        // Reset asserted in the third wait cycle
        ex_mc_start = 1'b1;
        cyc();
        idle();
        cyc();
        cyc();
        check("rmc_stall_cnt", 32'(stall_cnt), 18);
        rst_n = 1'b0;
        #1;
        check("rmc_rst_pc_en", 32'(pc_en), 0);
        check("rmc_rst_flush", 32'(if_id_flush), 1);
        cyc();
        rst_n = 1'b1;
        ex_rs1 = 5'd5; mem_rd = 5'd5; mem_reg_write = 1'b1;
        #1;
        check("rmc_init_pc_en", 32'(pc_en), 0);
        check("rmc_init_stall_cnt", 32'(stall_cnt), 0);
        check("rmc_init_fwd_a", 32'(fwd_a), 0);
        check("rmc_init_mc_timeout", 32'(mc_timeout), 0);
        cyc();
        idle();
        check("rmc_init1_pc_en", 32'(pc_en), 0);
        cyc();
        check("rmc_run_pc_en", 32'(pc_en), 1);
        check("rmc_run_stall_cnt", 32'(stall_cnt), 2);
        repeat (8) cyc();
        check("rmc_no_timeout", 32'(mc_timeout), 0);
        check("rmc_final_stall_cnt", 32'(stall_cnt), 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
